spi_slave_reg_ctrl: RTL and testbench

//  CLK-domain controller that sequences the SCLK-domain SPI slave byte engine. Turns its byte stream

---
 rtl/spi_slave_reg_ctrl_if.sv | 27 ++
 rtl/spi_slave_reg_ctrl.sv | 145 ++++++++++++++
 tb/tb_spi_slave_reg_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_reg_ctrl_if.sv
// Bus between the CLK-domain register controller and the SPI byte engine / FPGA fabric.
// REG_Q exposes the whole register file, register k at [8k+7:8k].
interface spi_slave_reg_ctrl_if #(
    parameter int NREGS = 16,
    parameter int AW    = 4
);
    logic               SS;
    logic               END_BIT;
    logic [7:0]         DATA_IN;
    logic [7:0]         DATA_OUT;
    logic [8*NREGS-1:0] REG_Q;
    logic               WR_STB;
    logic [AW-1:0]      WR_ADDR;
    logic [7:0]         WR_DATA;
    logic               BUSY;
    logic               ERR;

    modport master (
        output SS, END_BIT, DATA_IN,
        input  DATA_OUT, REG_Q, WR_STB, WR_ADDR, WR_DATA, BUSY, ERR
    );

    modport slave (
        input  SS, END_BIT, DATA_IN,
        output DATA_OUT, REG_Q, WR_STB, WR_ADDR, WR_DATA, BUSY, ERR
    );
endinterface

// File: rtl/spi_slave_reg_ctrl.sv
// Sequences the SCLK-domain SPI byte engine from the CLK domain: byte0 is {RW, ADDR[6:0]},
// later bytes are an auto-incrementing burst into or out of an NREGS x 8 register file.
module spi_slave_reg_ctrl #(
    parameter int         NREGS   = 16,
    parameter int         AW      = 4,
    parameter logic [7:0] IDLE_TX = 8'hA5
) (
    input  logic               CLK,
    input  logic               RST_N,
    spi_slave_reg_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t state, state_next;

    logic ss_p0, ss_p1, ss_p2;
    logic eb_p0, eb_p1, eb_p2;
    logic ss_fall, byte_done;
    logic cmd_done, data_done;

    logic       rw;
    logic [6:0] addr;
    logic [6:0] addr_inc;
    logic [7:0] regs [NREGS];
    logic [7:0] data_out;
    logic       wr_stb;
    logic [AW-1:0] wr_addr;
    logic [7:0] wr_data;
    logic       err;

    function automatic logic in_range(input logic [6:0] a);
        return (32'(a) < NREGS);
    endfunction

    function automatic logic [7:0] rd_byte(input logic [6:0] a);
        return in_range(a) ? regs[a[AW-1:0]] : 8'hFF;
    endfunction

    // Stage p0/p1: 2-FF synchronisers; p2: extra stage for edge detection
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ss_p0 <= 1'b0;
            ss_p1 <= 1'b0;
            ss_p2 <= 1'b0;
            eb_p0 <= 1'b0;
            eb_p1 <= 1'b0;
            eb_p2 <= 1'b0;
        end else begin
            ss_p0 <= bus.SS;
            ss_p1 <= ss_p0;
            ss_p2 <= ss_p1;
            eb_p0 <= bus.END_BIT;
            eb_p1 <= eb_p0;
            eb_p2 <= eb_p1;
        end
    end

    // Sync chains reset to 0, so SS held low across reset release never looks like a new frame.
    assign ss_fall   = ss_p2 & ~ss_p1;
    assign byte_done = eb_p2 & ~eb_p1 & ~ss_p1;
    assign addr_inc  = addr + 7'd1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        cmd_done   = 1'b0;
        data_done  = 1'b0;
        case (state)
            IDLE: if (ss_fall) state_next = CMD;
            CMD: begin
                if (ss_p1) begin
                    state_next = IDLE;
                end else if (byte_done) begin
                    cmd_done   = 1'b1;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (ss_p1) state_next = IDLE;
                else if (byte_done) data_done = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage p3: command decode, register file update and next transmit byte
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rw       <= 1'b0;
            addr     <= 7'd0;
            data_out <= IDLE_TX;
            wr_stb   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 8'd0;
            err      <= 1'b0;
            for (int k = 0; k < NREGS; k++) regs[k] <= 8'd0;
        end else begin
            wr_stb <= 1'b0;
            err    <= 1'b0;
            if (ss_p1 || state == IDLE) data_out <= IDLE_TX;
            if (cmd_done) begin
                rw   <= bus.DATA_IN[7];
                addr <= bus.DATA_IN[6:0];
                if (bus.DATA_IN[7]) begin
                    data_out <= rd_byte(bus.DATA_IN[6:0]);
                    err      <= ~in_range(bus.DATA_IN[6:0]);
                end
            end
            if (data_done) begin
                if (!rw) begin
                    if (in_range(addr)) begin
                        regs[addr[AW-1:0]] <= bus.DATA_IN;
                        wr_stb  <= 1'b1;
                        wr_addr <= addr[AW-1:0];
                        wr_data <= bus.DATA_IN;
                    end else begin
                        err <= 1'b1;
                    end
                end else begin
                    // Received byte is a dummy during reads; prefetch the next address instead.
                    data_out <= rd_byte(addr_inc);
                    err      <= ~in_range(addr_inc);
                end
                addr <= addr_inc;
            end
        end
    end

    for (genvar k = 0; k < NREGS; k++) begin : g_regq
        assign bus.REG_Q[8*k +: 8] = regs[k];
    end

    assign bus.DATA_OUT = data_out;
    assign bus.WR_STB   = wr_stb;
    assign bus.WR_ADDR  = wr_addr;
    assign bus.WR_DATA  = wr_data;
    assign bus.ERR      = err;
    assign bus.BUSY     = (state != IDLE);

endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// Directed bench for spi_slave_reg_ctrl: a simple behavioural byte engine drives END_BIT/DATA_IN
// and captures DATA_OUT at the start of each byte, as the real engine would load its shifter.
module tb_spi_slave_reg_ctrl;

    localparam int NREGS = 16;
    localparam int AW    = 4;

    logic CLK;
    logic RST_N;

    spi_slave_reg_ctrl_if #(.NREGS(NREGS), .AW(AW)) bus ();

    spi_slave_reg_ctrl #(.NREGS(NREGS), .AW(AW), .IDLE_TX(8'hA5)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    int wr_cnt   = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    logic [AW-1:0] prev_wr_addr = '0;
    logic [AW-1:0] last_wr_addr = '0;

    always @(negedge CLK) begin
        if (bus.WR_STB) begin
            prev_wr_addr = last_wr_addr;
            last_wr_addr = bus.WR_ADDR;
            wr_cnt++;
        end
        if (bus.ERR) err_cnt++;
        if (bus.WR_STB && bus.ERR) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] reg_at(input int k);
        return bus.REG_Q[8*k +: 8];
    endfunction

    task automatic ss_low();
        bus.SS = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic ss_high();
        bus.SS = 1'b1;
        repeat (5) @(negedge CLK);
    endtask

    task automatic xfer(input logic [7:0] mosi, output logic [7:0] miso);
        miso = bus.DATA_OUT;
        bus.END_BIT = 1'b1;
        repeat (8) @(negedge CLK);
        bus.DATA_IN = mosi;
        bus.END_BIT = 1'b0;
        repeat (6) @(negedge CLK);
    endtask

    logic [7:0] m;
    int wr0, err0;

    initial begin
        RST_N       = 1'b0;
        bus.SS      = 1'b1;
        bus.END_BIT = 1'b0;
        bus.DATA_IN = 8'h00;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (4) @(negedge CLK);

        // Reset state
        chk("rst_data_out", bus.DATA_OUT, 8'hA5);
        chk("rst_regq_zero", bus.REG_Q === '0, 1);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_wr_stb", bus.WR_STB, 0);
        chk("rst_err", bus.ERR, 0);

        // SS falls -> BUSY within 3 CLK
        bus.SS = 1'b0;
        repeat (3) @(negedge CLK);
        chk("busy_after_ss", bus.BUSY, 1);
        @(negedge CLK);

        // Write burst 0x02, 0x11, 0x22
        wr0 = wr_cnt;
        xfer(8'h02, m);
        chk("wr_cmd_miso", m, 8'hA5);
        xfer(8'h11, m);
        xfer(8'h22, m);
        chk("wr_last_addr", bus.WR_ADDR, 3);
        chk("wr_last_data", bus.WR_DATA, 8'h22);
        ss_high();
        chk("wr_reg2", reg_at(2), 8'h11);
        chk("wr_reg3", reg_at(3), 8'h22);
        chk("wr_strobes", wr_cnt - wr0, 2);
        chk("wr_first_addr", prev_wr_addr, 2);
        chk("wr_idle_busy", bus.BUSY, 0);
        chk("wr_idle_dout", bus.DATA_OUT, 8'hA5);

        // Read burst 0x82, xx, xx
        wr0 = wr_cnt; err0 = err_cnt;
        ss_low();
        xfer(8'h82, m);
        chk("rd_cmd_miso", m, 8'hA5);
        xfer(8'h00, m);
        chk("rd_byte1", m, 8'h11);
        xfer(8'hFF, m);
        chk("rd_byte2", m, 8'h22);
        ss_high();
        chk("rd_no_write", wr_cnt - wr0, 0);
        chk("rd_no_err", err_cnt - err0, 0);
        chk("rd_reg2_kept", reg_at(2), 8'h11);
        chk("rd_reg3_kept", reg_at(3), 8'h22);

        // Put a value in the top register, then read across the end of the file
        ss_low();
        xfer(8'h0F, m);
        xfer(8'h5A, m);
        ss_high();
        chk("top_reg15", reg_at(15), 8'h5A);
        err0 = err_cnt;
        ss_low();
        xfer(8'h8F, m);
        chk("oor_cmd_err", err_cnt - err0, 0);
        xfer(8'h00, m);
        chk("oor_rd_reg15", m, 8'h5A);
        chk("oor_err_2nd", err_cnt - err0, 1);
        xfer(8'h00, m);
        chk("oor_rd_ff", m, 8'hFF);
        ss_high();

        // Write 0x7F,0x55,0x66: 7F invalid, wrapped 0 valid
        wr0 = wr_cnt; err0 = err_cnt;
        ss_low();
        xfer(8'h7F, m);
        xfer(8'h55, m);
        chk("wrap_err_7f", err_cnt - err0, 1);
        chk("wrap_no_wr_7f", wr_cnt - wr0, 0);
        xfer(8'h66, m);
        ss_high();
        chk("wrap_reg0", reg_at(0), 8'h66);
        chk("wrap_wr_cnt", wr_cnt - wr0, 1);
        chk("wrap_err_cnt", err_cnt - err0, 1);
        chk("wrap_wr_addr", bus.WR_ADDR, 0);
        chk("wrap_wr_data", bus.WR_DATA, 8'h66);
        chk("stb_err_overlap", both_cnt, 0);

        // Abort after 4 bits of a data byte
        wr0 = wr_cnt;
        ss_low();
        xfer(8'h04, m);
        bus.END_BIT = 1'b1;
        repeat (4) @(negedge CLK);
        bus.SS = 1'b1;
        @(negedge CLK);
        bus.DATA_IN = 8'h77;
        bus.END_BIT = 1'b0;
        repeat (6) @(negedge CLK);
        chk("abort_reg4", reg_at(4), 8'h00);
        chk("abort_no_wr", wr_cnt - wr0, 0);
        chk("abort_busy", bus.BUSY, 0);
        chk("abort_dout", bus.DATA_OUT, 8'hA5);
        ss_low();
        xfer(8'h05, m);
        xfer(8'h33, m);
        ss_high();
        chk("post_abort_reg5", reg_at(5), 8'h33);
        chk("post_abort_addr", bus.WR_ADDR, 5);
        chk("post_abort_reg4", reg_at(4), 8'h00);

        // Reset mid-burst with SS held low
        ss_low();
        xfer(8'h06, m);
        xfer(8'h44, m);
        chk("pre_rst_reg6", reg_at(6), 8'h44);
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        chk("mid_rst_regq", bus.REG_Q === '0, 1);
        chk("mid_rst_busy", bus.BUSY, 0);
        chk("mid_rst_dout", bus.DATA_OUT, 8'hA5);
        wr0 = wr_cnt;
        xfer(8'h07, m);
        xfer(8'h99, m);
        chk("ignored_no_wr", wr_cnt - wr0, 0);
        chk("ignored_regq", bus.REG_Q === '0, 1);
        chk("ignored_busy", bus.BUSY, 0);
        ss_high();
        ss_low();
        chk("reframe_busy", bus.BUSY, 1);
        xfer(8'h08, m);
        xfer(8'hBB, m);
        ss_high();
        chk("reframe_reg8", reg_at(8), 8'hBB);
        chk("reframe_reg7", reg_at(7), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
